// File: rtl/mux_scan_pkg.sv
// Shared encodings for the scanning N:1 multiplexer.
package mux_scan_pkg;

  localparam logic MODE_SEL  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  typedef enum logic {
    ST_SEL  = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Mode FSM, dwell counter and scan pointer for mux_scan_nx1.
// Produces the effective channel index, a load-enable for the output
// registers, the next values of valid/wrap and an out-of-range flag.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int N  = 16,
  parameter int DW = 4,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] s_i,
  input  logic          mode_i,
  input  logic          en_i,
  input  logic [DW-1:0] dwell_i,
  output logic [SW-1:0] idx_o,
  output logic          ld_o,
  output logic          valid_d_o,
  output logic          wrap_d_o,
  output logic          oor_o
);

  state_e        state_q;
  logic [SW-1:0] p_q;
  logic [DW-1:0] c_q;
  logic          p_last;
  logic          dwell_done;

  assign p_last     = (p_q == SW'(N - 1));
  assign dwell_done = (c_q >= dwell_i);

  // State, pointer and dwell counter; en=0 freezes everything, mode changes clear p/c.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SEL;
      p_q     <= '0;
      c_q     <= '0;
    end else if (en_i) begin
      case (state_q)
        ST_SEL: begin
          if (mode_i == MODE_SCAN) begin
            state_q <= ST_SCAN;
            p_q     <= '0;
            c_q     <= '0;
          end
        end
        ST_SCAN: begin
          if (mode_i == MODE_SEL) begin
            state_q <= ST_SEL;
            p_q     <= '0;
            c_q     <= '0;
          end else if (dwell_done) begin
            c_q <= '0;
            p_q <= p_last ? '0 : p_q + SW'(1);
          end else begin
            c_q <= c_q + DW'(1);
          end
        end
        default: state_q <= ST_SEL;
      endcase
    end
  end

  // Next-cycle output controls; transition cycles load nothing and drop valid/wrap.
  always_comb begin
    idx_o     = '0;
    ld_o      = 1'b0;
    valid_d_o = 1'b0;
    wrap_d_o  = 1'b0;
    oor_o     = 1'b0;
    if (en_i) begin
      case (state_q)
        ST_SEL: begin
          if (mode_i == MODE_SEL) begin
            idx_o     = s_i;
            ld_o      = 1'b1;
            oor_o     = (32'(s_i) >= 32'(N));
            valid_d_o = ~oor_o;
          end
        end
        ST_SCAN: begin
          if (mode_i == MODE_SCAN) begin
            idx_o     = p_q;
            ld_o      = 1'b1;
            valid_d_o = dwell_done;
            wrap_d_o  = dwell_done & p_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N:1 multiplexer with external-select and self-scanning modes.
// Optional parity output enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_nx1
  import mux_scan_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int W  = 8,
  parameter  int DW = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] I,
  input  logic [SW-1:0]  S,
  input  logic           mode,
  input  logic           en,
  input  logic [DW-1:0]  dwell,
  output logic [W-1:0]   O,
  output logic [SW-1:0]  ch,
  output logic           valid,
  output logic           wrap
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic           par
`endif
);

  logic [SW-1:0] idx_w;
  logic          ld_w;
  logic          valid_d_w;
  logic          wrap_d_w;
  logic          oor_w;
  logic [W-1:0]  sel_w;
  logic [W-1:0]  load_w;

  mux_scan_ctrl #(
    .N  (N),
    .DW (DW),
    .SW (SW)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .s_i       (S),
    .mode_i    (mode),
    .en_i      (en),
    .dwell_i   (dwell),
    .idx_o     (idx_w),
    .ld_o      (ld_w),
    .valid_d_o (valid_d_w),
    .wrap_d_o  (wrap_d_w),
    .oor_o     (oor_w)
  );

  // Channel slice select; an out-of-range index loads zero.
  always_comb begin
    sel_w = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(idx_w) == k) sel_w = I[k*W +: W];
    end
    load_w = oor_w ? '0 : sel_w;
  end

  // Output registers: data/index load only when enabled, valid/wrap update every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      O     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      valid <= valid_d_w;
      wrap  <= wrap_d_w;
      if (ld_w) begin
        O  <= load_w;
        ch <= idx_w;
      end
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  // Parity of the value loaded into O, held alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (ld_w) begin
      par <= ^load_w;
    end
  end
`endif

endmodule
